datapath_r_multiciclo: RTL and testbench
========================================

# datapath_r_multiciclo

Parametrised multicycle successor to the single-cycle R-type datapath. It accepts one MIPS R-type instruction at a time over a valid/ready handshake. Each instruction runs through a four-state FSM: register read, ALU, write-back. The block owns its register file and reports Zflag, result, done and error, and it sits between the future fetch unit and the register/ALU core.

## Interface
Parameters:
- WIDTH, 32, data width of registers and ALU (8..32)
- NREGS, 32, implemented registers (2..32); addresses ≥ NREGS read 0, writes ignored

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- instruction  in  32  MIPS R-format word
- instr_valid  in  1  instruction present
- instr_ready  out  1  block idle, can accept
- result  out  WIDTH  last ALU result
- Zflag  out  1  last ALU result == 0
- done  out  1  one-cycle pulse, instruction retired
- err  out  1  one-cycle pulse with done, illegal instruction
- dbg_addr  in  5  debug read address
- dbg_data  out  WIDTH  combinational read of register dbg_addr ($0 reads 0)

## Operation
- FSM states are IDLE, DECODE, EXECUTE and WRITEBACK.
- IDLE: instr_ready=1. On instr_valid & instr_ready, latch instruction into IR and go to DECODE.
- DECODE: read rs and rt into A and B. Decode opcode and funct. Go to EXECUTE.
- EXECUTE: compute ALUOut and update result and Zflag. Go to WRITEBACK.
- WRITEBACK: write ALUOut to rd unless rd==0, rd≥NREGS, or the instruction is illegal. Pulse done, plus err if illegal. Return to IDLE.
- Supported functs:
  - add 100000, sub 100010, and 100100, or 100101, nor 100111
  - slt 101010: signed compare, result 1 or 0 zero-extended
  - sll 000000, srl 000010, sra 000011: shift rt by shamt
- Arithmetic wraps modulo 2^WIDTH. There is no overflow trap.
- Shifts with shamt ≥ WIDTH: sll/srl give 0; sra gives all copies of the sign bit.
- Illegal instruction: opcode≠0 or unlisted funct. result is forced to 0 and Zflag=1, no register write, err pulses.
- Register $0 always reads 0.
- The register file is not cleared by rst; its contents are preserved so the bench can preload it.

## Timing
- Accept on edge k. A/B valid after edge k+1. result/Zflag valid after k+2. Register written and done/err high after k+3 for exactly one cycle.
- Throughput is one instruction per 4 cycles. instr_ready is low from edge k until edge k+3, and high again in the same cycle done is high.
- The write is visible on dbg_data in the cycle done is high.
- Back-to-back dependent instructions need no forwarding, because the write completes before the next DECODE.
- instr_valid while busy is ignored. The instruction is not queued, and the source must hold it until ready.
- Reset values: state=IDLE, instr_ready=1, result=0, Zflag=0, done=0, err=0, IR=0.
- rst asserted mid-instruction aborts it immediately. There is no register write and no done; any register write not yet performed is lost.
- result and Zflag hold their value between instructions.

## Structure
- Shared package `mips_r_pkg`:
  - funct localparams
  - OPCODE_R = 6'b000000
  - FSM state typedef
  - instruction field slice helpers for rs, rt, rd, shamt, funct
- Sub-module `banco_de_registros_param`, parametrised by WIDTH and NREGS:
  - two async read ports and one debug read port
  - one synchronous write port
  - storage array `mem`, preloadable by hierarchical `$readmemb`
- The ALU stays inline in the top module as a combinational case on funct.

## Test plan
- Preload r1=5, r2=3. Issue add r4,r0,r1 (0x00012020), then sub r5,r1,r2 (0x00222822). Required: r4=5 and r5=2, each done exactly 4 cycles after accept, Zflag=0.
- Preload r2=3, r3=0xFFFFFFFF. Issue slt r6,r2,r3 (0x0043302A). Required: r6=0 (signed 3 > −1) and Zflag=1. Then slt r6,r3,r2 gives r6=1.
- Preload r7=0x7FFFFFFF, r8=1. Issue add r9,r7,r8. Required: r9=0x80000000 with no err (wrap). Then sra r10,r9,4 gives 0xF8000000; srl gives 0x08000000.
- Issue add r0,r1,r2. Required: done pulses, r0 still reads 0. Issue opcode 0x23 (lw): err and done pulse together, result=0, Zflag=1, no register changed.
- Assert rst during EXECUTE of add r11,r1,r2. Required: r11 unchanged, no done, instr_ready=1 immediately. Then re-issue and complete normally.
- Rebuild with WIDTH=8, NREGS=8. Preload r1=0xFF, r2=0x01; add r3,r1,r2 gives r3=0x00 and Zflag=1. Writes to rd=12 are dropped, and dbg_addr=12 reads 0.

Source files
------------

// File: rtl/mips_r_pkg.sv
// Shared definitions for the multicycle R-type datapath.
// Latency: n/a (types, constants and pure field-slice helpers only).
// Backpressure: n/a.
//
// Contents: R-format opcode, supported funct codes, FSM state type,
// instruction field slicers and the legality decoder.
package mips_r_pkg;

    localparam logic [5:0] OPCODE_R   = 6'b000000;

    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    function automatic logic [5:0] f_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] instr);
        return instr[15:11];
    endfunction

    function automatic logic [4:0] f_shamt(input logic [31:0] instr);
        return instr[10:6];
    endfunction

    function automatic logic [5:0] f_funct(input logic [31:0] instr);
        return instr[5:0];
    endfunction

    // Legal means R-format opcode and one of the nine implemented functs.
    function automatic logic is_legal(input logic [31:0] instr);
        logic ok;
        ok = 1'b0;
        if (f_opcode(instr) == OPCODE_R) begin
            case (f_funct(instr))
                FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
                FUNCT_ADD, FUNCT_SUB, FUNCT_AND,
                FUNCT_OR,  FUNCT_NOR, FUNCT_SLT: ok = 1'b1;
                default:                         ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/banco_de_registros_param.sv
// Register file: NREGS x WIDTH, two async read ports, one async debug port, one sync write port.
// Latency: reads combinational; write lands on the clock edge where we is high.
// Backpressure: none, always accepts a write.
//
// Ports: clk; we/wr_addr/wr_data write port; rd_addr_a/rd_data_a and
// rd_addr_b/rd_data_b operand reads; dbg_addr/dbg_data debug read.
// $0 and any address >= NREGS read as 0 and are never written.
// Storage is deliberately not reset so it can be preloaded from outside.
module banco_de_registros_param #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             we,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [4:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic [4:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [WIDTH-1:0] mem [0:NREGS-1];

    function automatic logic in_range(input logic [4:0] addr);
        return (int'(addr) < NREGS);
    endfunction

    function automatic logic [WIDTH-1:0] read_reg(input logic [4:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        if (addr != 5'd0 && in_range(addr)) begin
            val = mem[addr[AW-1:0]];
        end
        return val;
    endfunction

    assign rd_data_a = read_reg(rd_addr_a);
    assign rd_data_b = read_reg(rd_addr_b);
    assign dbg_data  = read_reg(dbg_addr);

    always_ff @(posedge clk) begin
        if (we && wr_addr != 5'd0 && in_range(wr_addr)) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/datapath_r_multiciclo.sv
// Multicycle MIPS R-type datapath: IDLE -> DECODE -> EXECUTE -> WRITEBACK, owns its register file.
// Latency: accept on edge k, result/Zflag after k+2, register write and done/err after k+3.
// Backpressure: instr_ready only in IDLE; instr_valid while busy is ignored, not queued.
//
// Ports: clk, rst (async, active-high); instruction/instr_valid/instr_ready
// input handshake; result/Zflag last ALU outcome (held between instructions);
// done/err one-cycle retire pulses; dbg_addr/dbg_data combinational register peek.
module datapath_r_multiciclo
    import mips_r_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [WIDTH-1:0] result,
    output logic             Zflag,
    output logic             done,
    output logic             err,
    input  logic [4:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_t           state;
    state_t           state_nxt;

    logic [31:0]      ir;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             illegal_q;

    logic             ir_load;
    logic             ab_load;
    logic             alu_load;
    logic             wb_stage;

    logic [WIDTH-1:0] rs_dat;
    logic [WIDTH-1:0] rt_dat;
    logic [WIDTH-1:0] alu_res;
    logic             rf_we;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (instr_valid) state_nxt = DECODE;
            DECODE:    state_nxt = EXECUTE;
            EXECUTE:   state_nxt = WRITEBACK;
            WRITEBACK: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs / datapath enables
    // ---------------------------------------------------------------
    always_comb begin
        instr_ready = 1'b0;
        ir_load     = 1'b0;
        ab_load     = 1'b0;
        alu_load    = 1'b0;
        wb_stage    = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                ir_load     = instr_valid;
            end
            DECODE:    ab_load  = 1'b1;
            EXECUTE:   alu_load = 1'b1;
            WRITEBACK: wb_stage = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------
    // result doubles as the ALUOut register: it is loaded in EXECUTE and
    // is what WRITEBACK stores. rd >= NREGS is also filtered in the file.
    assign rf_we = wb_stage && !illegal_q && (f_rd(ir) != 5'd0)
                   && (int'(f_rd(ir)) < NREGS);

    banco_de_registros_param #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rf (
        .clk       (clk),
        .we        (rf_we),
        .wr_addr   (f_rd(ir)),
        .wr_data   (result),
        .rd_addr_a (f_rs(ir)),
        .rd_data_a (rs_dat),
        .rd_addr_b (f_rt(ir)),
        .rd_data_b (rt_dat),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // ---------------------------------------------------------------
    // ALU (combinational on the latched operands and IR)
    // ---------------------------------------------------------------
    // Shift amounts >= WIDTH fall out of the language semantics:
    // << and >> give 0, >>> on a signed operand fills with the sign bit.
    always_comb begin
        alu_res = '0;
        if (!illegal_q) begin
            case (f_funct(ir))
                FUNCT_ADD: alu_res = a_reg + b_reg;
                FUNCT_SUB: alu_res = a_reg - b_reg;
                FUNCT_AND: alu_res = a_reg & b_reg;
                FUNCT_OR:  alu_res = a_reg | b_reg;
                FUNCT_NOR: alu_res = ~(a_reg | b_reg);
                FUNCT_SLT: alu_res = {{(WIDTH-1){1'b0}},
                                      ($signed(a_reg) < $signed(b_reg))};
                FUNCT_SLL: alu_res = b_reg << f_shamt(ir);
                FUNCT_SRL: alu_res = b_reg >> f_shamt(ir);
                FUNCT_SRA: alu_res = $signed(b_reg) >>> f_shamt(ir);
                default:   alu_res = '0;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            illegal_q <= 1'b0;
            result    <= '0;
            Zflag     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (ir_load) begin
                ir <= instruction;
            end
            if (ab_load) begin
                a_reg     <= rs_dat;
                b_reg     <= rt_dat;
                illegal_q <= !is_legal(ir);
            end
            // Illegal instructions yield alu_res == 0, hence Zflag = 1.
            if (alu_load) begin
                result <= alu_res;
                Zflag  <= (alu_res == '0);
            end
            // Pulses are registered so they appear alongside the write,
            // in the first IDLE cycle after WRITEBACK.
            done <= wb_stage;
            err  <= wb_stage && illegal_q;
        end
    end

endmodule

// File: tb/tb_datapath_r_multiciclo.sv
// Directed bench for datapath_r_multiciclo: a 32-bit/32-register instance
// and an 8-bit/8-register instance, registers preloaded hierarchically.
module tb_datapath_r_multiciclo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] result;
    logic        Zflag;
    logic        done;
    logic        err;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    // 8-bit instance
    logic        rst8;
    logic [31:0] instruction8;
    logic        instr_valid8;
    logic        instr_ready8;
    logic [7:0]  result8;
    logic        Zflag8;
    logic        done8;
    logic        err8;
    logic [4:0]  dbg_addr8;
    logic [7:0]  dbg_data8;

    int vec_cnt  = 0;
    int miscmp   = 0;

    localparam logic [31:0] SENT = 32'h0BAD_F00D;

    datapath_r_multiciclo #(.WIDTH(32), .NREGS(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .result      (result),
        .Zflag       (Zflag),
        .done        (done),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    datapath_r_multiciclo #(.WIDTH(8), .NREGS(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst8),
        .instruction (instruction8),
        .instr_valid (instr_valid8),
        .instr_ready (instr_ready8),
        .result      (result8),
        .Zflag       (Zflag8),
        .done        (done8),
        .err         (err8),
        .dbg_addr    (dbg_addr8),
        .dbg_data    (dbg_data8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    task automatic peek(input logic [4:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic peek8(input logic [4:0] a, output logic [7:0] v);
        dbg_addr8 = a;
        #1;
        v = dbg_data8;
    endtask

    // Issue one instruction on the 32-bit instance and wait for retirement.
    // Checks: done arrives 3 edges after the accept edge, ready is low while
    // busy and high with done, done lasts one cycle. Returns the rd contents
    // seen on dbg_data during the done cycle, and err in that cycle.
    task automatic exec32(input logic [31:0] ins, input string tag,
                          output logic [31:0] rd_at_done, output logic err_at_done);
        int  n;
        int  lat;
        bit  got;
        rd_at_done  = '0;
        err_at_done = 1'b0;
        @(negedge clk);
        instruction = ins;
        instr_valid = 1'b1;
        dbg_addr    = ins[15:11];
        n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) chk({tag, "_busy_ready"}, {31'd0, instr_ready}, 32'd0);
            if (done) begin
                got         = 1'b1;
                lat         = i;
                rd_at_done  = dbg_data;
                err_at_done = err;
                chk({tag, "_ready_with_done"}, {31'd0, instr_ready}, 32'd1);
            end
        end
        chk({tag, "_lat"}, lat, 32'd3);
        @(posedge clk);
        #1;
        chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
    endtask

    task automatic exec8(input logic [31:0] ins, input string tag);
        int n;
        bit got;
        @(negedge clk);
        instruction8 = ins;
        instr_valid8 = 1'b1;
        n = 0;
        while (!instr_ready8 && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        instr_valid8 = 1'b0;
        got = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done8) got = 1'b1;
        end
        chk({tag, "_done"}, {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  v8;
        logic        e;
        bit          any_done;

        rst          = 1'b1;
        rst8         = 1'b1;
        instruction  = '0;
        instr_valid  = 1'b0;
        dbg_addr     = '0;
        instruction8 = '0;
        instr_valid8 = 1'b0;
        dbg_addr8    = '0;

        // Preload (register file is not affected by reset).
        for (int i = 1; i < 32; i++) u_dut.u_rf.mem[i] = SENT;
        u_dut.u_rf.mem[1] = 32'd5;
        u_dut.u_rf.mem[2] = 32'd3;
        u_dut.u_rf.mem[3] = 32'hFFFF_FFFF;
        u_dut.u_rf.mem[7] = 32'h7FFF_FFFF;
        u_dut.u_rf.mem[8] = 32'd1;
        for (int i = 1; i < 8; i++) u_dut8.u_rf.mem[i] = 8'h5A;
        u_dut8.u_rf.mem[1] = 8'hFF;
        u_dut8.u_rf.mem[2] = 8'h01;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  {31'd0, instr_ready}, 32'd1);
        chk("rst_result", result, 32'd0);
        chk("rst_zflag",  {31'd0, Zflag}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_err",    {31'd0, err}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        rst8 = 1'b0;

        // add r4,r0,r1 ; sub r5,r1,r2
        exec32(32'h0001_2020, "add_r4", v, e);
        chk("add_r4_val", v, 32'd5);
        chk("add_r4_z", {31'd0, Zflag}, 32'd0);
        exec32(32'h0022_2822, "sub_r5", v, e);
        chk("sub_r5_val", v, 32'd2);
        chk("sub_r5_z", {31'd0, Zflag}, 32'd0);
        chk("sub_r5_err", {31'd0, e}, 32'd0);

        // slt both directions
        exec32(32'h0043_302A, "slt_a", v, e);
        chk("slt_a_val", v, 32'd0);
        chk("slt_a_z", {31'd0, Zflag}, 32'd1);
        exec32(32'h0062_302A, "slt_b", v, e);
        chk("slt_b_val", v, 32'd1);

        // wrap and shifts
        exec32(r_type(5'd7, 5'd8, 5'd9, 5'd0, 6'b100000), "add_wrap", v, e);
        chk("add_wrap_val", v, 32'h8000_0000);
        chk("add_wrap_err", {31'd0, e}, 32'd0);
        exec32(r_type(5'd0, 5'd9, 5'd10, 5'd4, 6'b000011), "sra", v, e);
        chk("sra_val", v, 32'hF800_0000);
        exec32(r_type(5'd0, 5'd9, 5'd10, 5'd4, 6'b000010), "srl", v, e);
        chk("srl_val", v, 32'h0800_0000);
        exec32(r_type(5'd0, 5'd1, 5'd15, 5'd31, 6'b000000), "sll", v, e);
        chk("sll_val", v, 32'h8000_0000);

        // logic ops
        exec32(r_type(5'd1, 5'd2, 5'd12, 5'd0, 6'b100100), "and", v, e);
        chk("and_val", v, 32'd1);
        exec32(r_type(5'd1, 5'd2, 5'd13, 5'd0, 6'b100101), "or", v, e);
        chk("or_val", v, 32'd7);
        exec32(r_type(5'd1, 5'd2, 5'd14, 5'd0, 6'b100111), "nor", v, e);
        chk("nor_val", v, 32'hFFFF_FFF8);

        // write to r0 dropped
        exec32(r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'b100000), "add_r0", v, e);
        chk("add_r0_reads0", v, 32'd0);
        chk("add_r0_result", result, 32'd8);

        // illegal funct (jr) targeting r4
        exec32(r_type(5'd1, 5'd2, 5'd4, 5'd0, 6'b001000), "ill_funct", v, e);
        chk("ill_funct_err", {31'd0, e}, 32'd1);
        chk("ill_funct_r4", v, 32'd5);
        chk("ill_funct_res", result, 32'd0);

        // lw: illegal opcode, rd field 9
        exec32(32'h8C22_4800, "lw", v, e);
        chk("lw_err", {31'd0, e}, 32'd1);
        chk("lw_result", result, 32'd0);
        chk("lw_zflag", {31'd0, Zflag}, 32'd1);
        chk("lw_r9", v, 32'h8000_0000);
        peek(5'd2, v);
        chk("lw_r2", v, 32'd3);

        // reset during EXECUTE of add r11,r1,r2
        @(negedge clk);
        instruction = r_type(5'd1, 5'd2, 5'd11, 5'd0, 6'b100000);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        any_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            any_done = any_done | done;
        end
        chk("abort_no_done", {31'd0, any_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        peek(5'd11, v);
        chk("abort_r11", v, SENT);
        exec32(r_type(5'd1, 5'd2, 5'd11, 5'd0, 6'b100000), "reissue", v, e);
        chk("reissue_r11", v, 32'd8);

        // 8-bit instance
        exec8(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), "w8_add");
        peek8(5'd3, v8);
        chk("w8_add_r3", {24'd0, v8}, 32'd0);
        chk("w8_add_z", {31'd0, Zflag8}, 32'd1);
        exec8(r_type(5'd1, 5'd1, 5'd12, 5'd0, 6'b100000), "w8_rd12");
        chk("w8_rd12_res", {24'd0, result8}, 32'h0000_00FE);
        peek8(5'd12, v8);
        chk("w8_dbg12", {24'd0, v8}, 32'd0);
        exec8(r_type(5'd0, 5'd1, 5'd4, 5'd9, 6'b000011), "w8_sra");
        peek8(5'd4, v8);
        chk("w8_sra_big", {24'd0, v8}, 32'h0000_00FF);
        exec8(r_type(5'd0, 5'd1, 5'd5, 5'd9, 6'b000010), "w8_srl");
        peek8(5'd5, v8);
        chk("w8_srl_big", {24'd0, v8}, 32'd0);
        exec8(r_type(5'd0, 5'd1, 5'd6, 5'd8, 6'b000000), "w8_sll");
        peek8(5'd6, v8);
        chk("w8_sll_big", {24'd0, v8}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
